bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for NUM_REQ driver_bus instances that share one
// data bus. Only one enable is ever high. A change of owner always passes through a one-cycle
// turnaround with every enable low.
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to compile in the hold counter. With it, an owner
// that has held the bus for MAX_HOLD cycles while another requester waits is forced off the
// bus. Without it, hold_timeout is tied low and the owner releases only by dropping req.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   MAX_HOLD     OWN cycles before a forced release (2..255)
// Ports
//   clk          clock, rising edge
//   rst_         asynchronous active-low reset
//   req          level-sensitive request, bit i belongs to requester i
//   data_e       registered one-hot-or-zero enables, bit i drives driver_bus i
//   grant_id     index of the current owner (keeps the last owner while idle)
//   bus_busy     high whenever any data_e bit is high
//   hold_timeout one-cycle pulse in the turnaround that follows a forced release
module bus_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         data_e,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       bus_busy,
   output logic                       hold_timeout
);

   localparam int unsigned IdW   = $clog2(NUM_REQ);
   localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("bus_arbiter: NUM_REQ must be in 2..8");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("bus_arbiter: MAX_HOLD must be in 2..255");
   end

   typedef enum logic [1:0] {
      StIdle,
      StOwn,
      StTurn
   } state_e;

   state_e             state_q;
   logic [NUM_REQ-1:0] data_e_q;
   logic [IdW-1:0]     grant_id_q;
   logic [IdW-1:0]     last_owner_q;
   logic               bus_busy_q;

   // Round-robin search: first set req bit starting just after the last owner.
   logic               pick_valid;
   logic [IdW-1:0]     pick_idx;
   logic [IdW-1:0]     cand_idx;
   int unsigned        cand;

   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand     = (32'(last_owner_q) + k) % NUM_REQ;
         cand_idx = IdW'(cand);
         if (!pick_valid && req[cand_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   logic [HoldW-1:0]   hold_cnt_q;
   logic               hold_timeout_q;
   logic [NUM_REQ-1:0] others;

   // Requests from everyone except the current owner.
   always_comb begin
      others             = req;
      others[grant_id_q] = 1'b0;
   end
`endif

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q        <= StIdle;
         data_e_q       <= '0;
         grant_id_q     <= '0;
         last_owner_q   <= IdW'(NUM_REQ - 1);
         bus_busy_q     <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         hold_cnt_q     <= '0;
         hold_timeout_q <= 1'b0;
`endif
      end else begin
`ifdef BUS_ARB_TIMEOUT_EN
         hold_timeout_q <= 1'b0;
`endif
         unique case (state_q)
            StIdle, StTurn: begin
               // TURN always lasts one cycle: grant directly or fall back to idle.
               if (pick_valid) begin
                  state_q      <= StOwn;
                  data_e_q     <= NUM_REQ'(1) << pick_idx;
                  grant_id_q   <= pick_idx;
                  last_owner_q <= pick_idx;
                  bus_busy_q   <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                  hold_cnt_q   <= '0;
`endif
               end else begin
                  state_q <= StIdle;
               end
            end
            StOwn: begin
               // A voluntary release wins over a coincident timeout, so no pulse then.
               if (!req[grant_id_q]) begin
                  state_q    <= StTurn;
                  data_e_q   <= '0;
                  bus_busy_q <= 1'b0;
               end
`ifdef BUS_ARB_TIMEOUT_EN
               // >= so that an owner that held alone past the limit is released as soon
               // as a competitor appears.
               else if ((hold_cnt_q >= HoldW'(MAX_HOLD - 1)) && (|others)) begin
                  state_q        <= StTurn;
                  data_e_q       <= '0;
                  bus_busy_q     <= 1'b0;
                  hold_timeout_q <= 1'b1;
               end else if (hold_cnt_q != HoldW'(MAX_HOLD)) begin
                  hold_cnt_q <= hold_cnt_q + HoldW'(1);
               end
`endif
            end
            default: begin
               state_q    <= StIdle;
               data_e_q   <= '0;
               bus_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_e   = data_e_q;
   assign grant_id = grant_id_q;
   assign bus_busy = bus_busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
   assign hold_timeout = hold_timeout_q;
`else
   assign hold_timeout = 1'b0;
`endif

endmodule
